// File: rtl/fx_vector_sum.sv
// Streams N floats from memory through the fx evaluator and returns
// the IEEE-754 single-precision sum of the f(x) results.
module fp_add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_q
);
  logic [7:0]  w_ea, w_eb, w_el, w_es, w_d;
  logic [23:0] w_ml, w_ms;
  logic        w_sl, w_ss, w_swap;
  logic        w_nan, w_ia, w_ib, w_rnd;
  logic [26:0] w_as;
  logic [27:0] w_s;
  logic [9:0]  w_e;
  logic [24:0] w_m;

  always_comb begin
    w_ea = (i_a[30:23] == 8'd0) ? 8'd1 : i_a[30:23];
    w_eb = (i_b[30:23] == 8'd0) ? 8'd1 : i_b[30:23];
    w_swap = i_b[30:0] > i_a[30:0];
    w_sl = w_swap ? i_b[31] : i_a[31];
    w_ss = w_swap ? i_a[31] : i_b[31];
    w_el = w_swap ? w_eb : w_ea;
    w_es = w_swap ? w_ea : w_eb;
    w_ml = w_swap ? {|i_b[30:23], i_b[22:0]}
                  : {|i_a[30:23], i_a[22:0]};
    w_ms = w_swap ? {|i_a[30:23], i_a[22:0]}
                  : {|i_b[30:23], i_b[22:0]};
    w_d = w_el - w_es;
    // Three extra bits below the LSB carry guard/round/sticky
    if (w_d > 8'd26) begin
      w_as = {26'd0, |w_ms};
    end else begin
      w_as = ({w_ms, 3'b000} >> w_d)
           | {26'd0, |({w_ms, 3'b000}
                       & ((27'd1 << w_d) - 27'd1))};
    end
    if (w_sl == w_ss) begin
      w_s = {1'b0, w_ml, 3'b000} + {1'b0, w_as};
    end else begin
      w_s = {1'b0, w_ml, 3'b000} - {1'b0, w_as};
    end
    w_e = {2'b00, w_el};
    if (w_s[27]) begin
      w_s = {1'b0, w_s[27:2], w_s[1] | w_s[0]};
      w_e = w_e + 10'd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!w_s[26] && w_e > 10'd1) begin
          w_s = w_s << 1;
          w_e = w_e - 10'd1;
        end
      end
    end
    w_rnd = w_s[2] & (w_s[1] | w_s[0] | w_s[3]);
    w_m = {1'b0, w_s[26:3]} + {24'd0, w_rnd};
    if (w_m[24]) begin
      w_m = {1'b0, w_m[24:1]};
      w_e = w_e + 10'd1;
    end
    w_nan = (&i_a[30:23] & |i_a[22:0])
          | (&i_b[30:23] & |i_b[22:0]);
    w_ia = &i_a[30:23] & ~|i_a[22:0];
    w_ib = &i_b[30:23] & ~|i_b[22:0];
    if (w_nan || (w_ia && w_ib && i_a[31] != i_b[31])) begin
      o_q = 32'h7FC0_0000;
    end else if (w_ia) begin
      o_q = {i_a[31], 8'hFF, 23'd0};
    end else if (w_ib) begin
      o_q = {i_b[31], 8'hFF, 23'd0};
    end else if (w_s == 28'd0) begin
      o_q = {w_sl & w_ss, 31'd0};
    end else if (w_e >= 10'd255) begin
      o_q = {w_sl, 8'hFF, 23'd0};
    end else begin
      // A subnormal that rounds up into bit 23 becomes the smallest normal
      o_q = {w_sl, w_m[23] ? w_e[7:0] : 8'd0, w_m[22:0]};
    end
  end
endmodule

module fx_vector_sum #(
  parameter int ADDR_W      = 16,
  parameter int ADD_LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       n,
  output logic              done,
  output logic [31:0]       result,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  output logic [31:0]       fx_x,
  output logic              fx_start,
  input  logic              fx_done,
  input  logic [31:0]       fx_result
);
  localparam int LW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_KICK   = 3'd3;
  localparam logic [2:0] S_EVAL   = 3'd4;
  localparam logic [2:0] S_ACC    = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  logic [2:0]        r_state;
  logic [31:0]       r_idx;
  logic [31:0]       r_cnt_cap;
  logic [ADDR_W-1:0] r_addr_cap;
  logic [31:0]       r_x;
  logic [31:0]       r_fx;
  logic [31:0]       r_sum;
  logic [31:0]       r_result;
  logic [LW-1:0]     r_lat;

  logic [31:0] w_q;
  logic [31:0] w_idx1;
  logic        w_last;

  fp_add u_fp_add (
    .i_a (r_sum),
    .i_b (r_fx),
    .o_q (w_q)
  );

  assign w_idx1 = r_idx + 32'd1;
  assign w_last = (r_lat == LW'(ADD_LATENCY - 1));

  assign mem_addr = r_addr_cap + r_idx[ADDR_W-1:0];
  assign mem_read = (r_state == S_FETCH) && clk_en;
  assign fx_start = (r_state == S_KICK) && clk_en;
  assign done     = (r_state == S_FINISH) && clk_en;
  assign fx_x     = r_x;
  // The finished sum is visible in the done cycle itself
  assign result   = (r_state == S_FINISH) ? r_sum : r_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt_cap  <= '0;
      r_addr_cap <= '0;
      r_x        <= '0;
      r_fx       <= '0;
      r_sum      <= '0;
      r_result   <= '0;
      r_lat      <= '0;
    end else if (!clk_en) begin
      r_state <= S_IDLE;
      r_lat   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt_cap  <= n;
            r_addr_cap <= base_addr;
            r_idx      <= '0;
            r_sum      <= '0;
            r_lat      <= '0;
            r_state    <= (n == 32'd0) ? S_FINISH : S_FETCH;
          end
        end
        S_FETCH: begin
          if (!mem_waitrequest) r_state <= S_DATA;
        end
        S_DATA: begin
          r_x     <= mem_readdata;
          r_state <= S_KICK;
        end
        S_KICK: begin
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          if (fx_done) begin
            r_fx    <= fx_result;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_last) begin
            r_lat   <= '0;
            r_sum   <= w_q;
            r_idx   <= w_idx1;
            r_state <= (w_idx1 == r_cnt_cap) ? S_FINISH : S_FETCH;
          end else begin
            r_lat <= r_lat + LW'(1);
          end
        end
        S_FINISH: begin
          r_result <= r_sum;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fx_vector_sum.sv
// Directed bench for fx_vector_sum: memory and fx models plus a
// scoreboard of expected sums and start-to-done latencies.
module tb_fx_vector_sum;
  localparam int AW  = 4;
  localparam int TFX = 4;
  localparam int PER = 3 + (TFX + 1) + 3;

  logic          clk = 1'b0;
  logic          reset, clk_en, start;
  logic [AW-1:0] base_addr;
  logic [31:0]   n;
  logic          done;
  logic [31:0]   result;
  logic [AW-1:0] mem_addr;
  logic          mem_read, mem_waitrequest;
  logic [31:0]   mem_readdata;
  logic [31:0]   fx_x;
  logic          fx_start;
  logic          fx_done = 1'b0;
  logic [31:0]   fx_result = 32'h0;

  int vectors = 0, miscompares = 0;
  int cyc = 0, ndone = 0, nrd = 0, nfs = 0;
  int stall_n = 0, stall_cnt = 0, fxc = 0;
  logic [31:0] mem [16];
  logic [31:0] rd_q = 32'h0;
  logic [31:0] fx_xl = 32'h0;
  logic        fx_busy = 1'b0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
  } job_t;
  job_t          sb[$];
  logic [AW-1:0] aq[$];

  always #5 clk = ~clk;

  fx_vector_sum #(.ADDR_W(AW), .ADD_LATENCY(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_en          (clk_en),
    .start           (start),
    .base_addr       (base_addr),
    .n               (n),
    .done            (done),
    .result          (result),
    .mem_addr        (mem_addr),
    .mem_read        (mem_read),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .fx_x            (fx_x),
    .fx_start        (fx_start),
    .fx_done         (fx_done),
    .fx_result       (fx_result)
  );

  // f(x) = x*x + x/2 for the operands used here
  function automatic logic [31:0] fx_f(input logic [31:0] x);
    case (x)
      32'h43000000: return 32'h46808000;
      32'h3F800000: return 32'h3FC00000;
      32'h40000000: return 32'h40A00000;
      32'hBE800000: return 32'hBD800000;
      default:      return 32'h00000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  assign mem_waitrequest = stall_cnt < stall_n;
  assign mem_readdata    = rd_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read && mem_waitrequest) stall_cnt <= stall_cnt + 1;
    else if (!mem_read) stall_cnt <= 0;
    if (mem_read && !mem_waitrequest) rd_q <= mem[mem_addr];
  end

  always @(posedge clk) begin
    fx_done   <= 1'b0;
    fx_result <= 32'hDEADBEEF;
    if (reset) begin
      fxc <= 0;
    end else if (fx_start) begin
      fxc   <= TFX;
      fx_xl <= fx_x;
    end else if (fxc != 0) begin
      fxc <= fxc - 1;
      if (fxc == 1) begin
        fx_done   <= 1'b1;
        fx_result <= fx_f(fx_xl);
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      fx_busy = 1'b0;
    end else begin
      if (mem_read) begin
        vectors++;
        assert (aq.size() != 0) else begin
          miscompares++;
          $error("FAIL rd_unexpected obs=%h exp=none", mem_addr);
        end
        if (aq.size() != 0) begin
          if (mem_waitrequest) chk("addr_stall", 32'(mem_addr), 32'(aq[0]));
          else begin
            chk("addr", 32'(mem_addr), 32'(aq.pop_front()));
            nrd++;
          end
        end
      end
      if (fx_busy && !fx_start) chk("fx_x_hold", fx_x, fx_xl);
      if (fx_start) begin
        chk("fx_overlap", 32'(fx_busy), 32'd0);
        fx_busy = 1'b1;
        nfs++;
      end
      if (fx_done) fx_busy = 1'b0;
      if (done) begin
        ndone++;
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("FAIL done_unexpected obs=%h exp=none", result);
        end
        if (sb.size() != 0) begin
          job_t j;
          j = sb.pop_front();
          chk("result", result, j.res);
          chk("latency", 32'(cyc - j.t0), 32'(j.lat));
        end
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] b, input int cnt,
                           input logic [31:0] res, input int lat);
    job_t j;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    n = 32'(cnt);
    j.res = res;
    j.lat = lat;
    j.t0  = cyc;
    sb.push_back(j);
    for (int i = 0; i < cnt; i++) aq.push_back(b + AW'(i));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int t = 0;
    while (ndone == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    assert (ndone > d0) else begin
      miscompares++;
      $error("FAIL %s_timeout obs=%0d exp=%0d", tag, ndone, d0 + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, result, 32'h0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_fx_start"}, 32'(fx_start), 32'd0);
    chk({tag, "_fx_x"}, fx_x, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1);
  end

  initial begin
    int d0, r0, f0, t;
    reset = 1'b1; clk_en = 1'b1; start = 1'b0;
    base_addr = '0; n = 32'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk); #1;
    chk_reset_outs("rst");
    reset = 1'b0;

    r0 = nrd; f0 = nfs; d0 = ndone;
    start_job(4'd2, 0, 32'h00000000, 1);
    wait_done(d0, "n0");
    chk("n0_reads", 32'(nrd), 32'(r0));
    chk("n0_fxstart", 32'(nfs), 32'(f0));

    mem[3] = 32'h43000000;
    d0 = ndone;
    start_job(4'd3, 1, 32'h46808000, 1 + PER);
    wait_done(d0, "single");

    mem[15] = 32'h43000000; mem[0] = 32'h0;
    d0 = ndone;
    start_job(4'd15, 2, 32'h46808000, 1 + 2 * PER);
    wait_done(d0, "wrap");

    mem[4] = 32'h43000000; mem[5] = 32'h3F800000; mem[6] = 32'h40000000;
    d0 = ndone;
    start_job(4'd4, 3, 32'h46808D00, 1 + 3 * PER);
    wait_done(d0, "three");

    mem[7] = 32'h40000000; mem[8] = 32'hBE800000;
    d0 = ndone;
    start_job(4'd7, 2, 32'h409E0000, 1 + 2 * PER);
    wait_done(d0, "subtract");

    stall_n = 5;
    d0 = ndone;
    start_job(4'd3, 1, 32'h46808000, 1 + PER + 5);
    wait_done(d0, "stall");

    stall_n = 3;
    d0 = ndone;
    start_job(4'd4, 2, 32'h46808300, 1 + 2 * PER + 6);
    start = 1'b1; base_addr = 4'd0; n = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, "ign_start");
    stall_n = 0;

    d0 = ndone;
    start_job(4'd4, 2, 32'h46808300, 1 + 2 * PER);
    t = 0;
    while (!fx_done && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    clk_en = 1'b0;
    @(posedge clk); #1;
    clk_en = 1'b1;
    void'(sb.pop_back());
    aq.delete();
    repeat (30) @(posedge clk); #1;
    chk("clken_nodone", 32'(ndone), 32'(d0));
    chk("clken_idle_rd", 32'(mem_read), 32'd0);
    d0 = ndone;
    start_job(4'd3, 1, 32'h46808000, 1 + PER);
    wait_done(d0, "after_clken");

    f0 = nfs; d0 = ndone;
    start_job(4'd4, 3, 32'h46808D00, 1 + 3 * PER);
    t = 0;
    while (nfs < f0 + 2 && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset_outs("abort");
    void'(sb.pop_back());
    aq.delete();
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("abort_nodone", 32'(ndone), 32'(d0));
    d0 = ndone;
    start_job(4'd3, 1, 32'h46808000, 1 + PER);
    wait_done(d0, "after_abort");

    repeat (5) @(posedge clk); #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
